// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// word packing constants and the default text-segment base address.
package imem_loader_pkg;

  // Loader sequencing; the numeric order is what dbg_state reports.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Bytes assembled into one little-endian instruction word.
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

  // Byte address of imem word 0 as seen by the CPU.
  localparam logic [31:0] TEXT_BASE_DEFAULT = 32'h0040_0000;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles accepted bytes into little-endian 32-bit words. Three bytes are
// held in a shift register; the fourth byte completes the word combinationally
// so the word can be written on the same edge that accepts its last byte.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [BYTE_CNT_W-1:0] cnt_q;
  logic [23:0]           hold_q;

  // Earlier bytes sit in the low lanes, so the arriving byte is the MSB lane.
  assign word_valid_o = byte_en_i && (cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));
  assign word_o       = {byte_i, hold_q};

  // Byte position counter and holding register; clear discards a partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      hold_q <= '0;
    end else if (clear_i) begin
      cnt_q  <= '0;
      hold_q <= '0;
    end else if (byte_en_i) begin
      cnt_q  <= cnt_q + BYTE_CNT_W'(1);
      hold_q <= {byte_i, hold_q[23:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Writer side of the instruction memory: takes a byte stream, packs it into
// 32-bit words, writes them through the imem write port and then releases the
// CPU from reset. All outputs come straight from registers.
//
// Byte handshake: a byte transfers on a rising edge where byte_valid and
// byte_ready are both high. byte_ready is registered and only high in LOAD;
// byte_valid may be held or dropped freely, and nothing transfers otherwise.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MAX_WORDS = 2 ** ADDR_W,
  parameter logic [31:0] TEXT_BASE = TEXT_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_a,
  output logic [31:0]       imem_d,
  output logic              cpu_rst,
  output logic              cpu_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded,
  output logic [31:0]       load_base,
  output logic [1:0]        dbg_state
);

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(MAX_WORDS);

  state_e            state_q, state_d;
  logic              byte_ready_q, byte_ready_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_a_q, imem_a_d;
  logic [31:0]       imem_d_q, imem_d_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              cpu_en_q, cpu_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic        start_ok;
  logic        accept;
  logic        pack_clear;
  logic        word_valid;
  logic [31:0] word;
  logic        last_word;

  // A start is only honoured for a non-empty program that fits in imem.
  assign start_ok = start && (word_count != '0) && (word_count <= MAX_CNT);

  // Abort wins over a byte arriving in the same cycle, so that byte never counts.
  assign accept = (state_q == ST_LOAD) && byte_valid && byte_ready_q && !abort;

  // Packer restarts on every honoured start and drops its partial word on abort.
  assign pack_clear = (((state_q == ST_IDLE) || (state_q == ST_DONE)) && start_ok) ||
                      (((state_q == ST_LOAD) || (state_q == ST_DRAIN)) && abort);

  // The word being completed is the last one when idx reaches word_count-1.
  assign last_word = (({1'b0, idx_q} + (ADDR_W + 1)'(1)) == count_q);

  imem_loader_byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (pack_clear),
    .byte_en_i    (accept),
    .byte_i       (byte_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  // Next-state and next-output logic for the load sequence.
  always_comb begin
    state_d      = state_q;
    byte_ready_d = byte_ready_q;
    imem_we_d    = 1'b0;
    imem_a_d     = imem_a_q;
    imem_d_d     = imem_d_q;
    cpu_rst_d    = cpu_rst_q;
    cpu_en_d     = cpu_en_q;
    busy_d       = busy_q;
    done_d       = done_q;
    err_d        = err_q;
    words_d      = words_q;
    idx_d        = idx_q;
    count_d      = count_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_d      = ST_LOAD;
          byte_ready_d = 1'b1;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          err_d        = 1'b0;
          cpu_rst_d    = 1'b1;
          cpu_en_d     = 1'b0;
          idx_d        = '0;
          words_d      = '0;
          count_d      = word_count;
        end else if (start) begin
          err_d = 1'b1;
        end
      end

      ST_LOAD: begin
        if (abort) begin
          state_d      = ST_IDLE;
          byte_ready_d = 1'b0;
          busy_d       = 1'b0;
          err_d        = 1'b1;
        end else if (word_valid) begin
          imem_we_d = 1'b1;
          imem_d_d  = word;
          imem_a_d  = idx_q;
          idx_d     = idx_q + ADDR_W'(1);
          words_d   = words_q + (ADDR_W + 1)'(1);
          if (last_word) begin
            state_d      = ST_DRAIN;
            byte_ready_d = 1'b0;
          end
        end
      end

      ST_DRAIN: begin
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          state_d   = ST_DONE;
          cpu_rst_d = 1'b0;
          cpu_en_d  = 1'b1;
          done_d    = 1'b1;
          busy_d    = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset holds the CPU and idles the write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_a_q     <= '0;
      imem_d_q     <= '0;
      cpu_rst_q    <= 1'b1;
      cpu_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      words_q      <= '0;
      idx_q        <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      byte_ready_q <= byte_ready_d;
      imem_we_q    <= imem_we_d;
      imem_a_q     <= imem_a_d;
      imem_d_q     <= imem_d_d;
      cpu_rst_q    <= cpu_rst_d;
      cpu_en_q     <= cpu_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      words_q      <= words_d;
      idx_q        <= idx_d;
      count_q      <= count_d;
    end
  end

  assign byte_ready   = byte_ready_q;
  assign imem_we      = imem_we_q;
  assign imem_a       = imem_a_q;
  assign imem_d       = imem_d_q;
  assign cpu_rst      = cpu_rst_q;
  assign cpu_en       = cpu_en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;
  assign load_base    = TEXT_BASE;
  assign dbg_state    = state_q;

endmodule
